// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV32I pipeline: datapath width, bubble encoding,
// fetch-stage states and the IF/ID register layout.
package rv_pipe_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

    typedef enum logic [1:0] {
        S_BOOT    = 2'd0,
        S_FETCH   = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. A bubble request wins over a load and turns the
// entry into a NOP with valid cleared; the PC field is left as it was.
module if_id_reg
    import rv_pipe_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t reg_q;
    if_id_t reg_d;

    // Select between hold, bubble insertion and a fresh load.
    always_comb begin
        reg_d = reg_q;
        if (bubble) begin
            reg_d.instr = NOP_INSTR;
            reg_d.valid = 1'b0;
        end else if (load) begin
            reg_d = d;
        end
    end

    // Register with asynchronous return to an empty bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
        end else begin
            reg_q <= reg_d;
        end
    end

    assign q = reg_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem handshake,
// one-entry hold buffer and the IF/ID register.
// Optional build macro IF_STALL_PERF_EN adds a saturating stall counter and
// a busy flag for the HOLD/DISCARD states.
module if_fetch_stage
    import rv_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCwrite,
    input  logic            IF_IDwrite,
    input  logic            flush,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic [XLEN-1:0] IF_ID_pc,
    output logic [31:0]     IF_ID_instr,
    output logic            IF_ID_valid
`ifdef IF_STALL_PERF_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic            stall_fsm_busy
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    if_id_t          hold_q, hold_d;

    logic            advance;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] flush_pc;
    logic            ifid_load;
    logic            ifid_bubble;
    if_id_t          ifid_din;
    if_id_t          ifid_q;

    // A mismatched PCwrite/IF_IDwrite pair is a stall; wrap is natural modulo.
    assign advance  = PCwrite & IF_IDwrite;
    assign pc_plus4 = pc_q + XLEN'(4);
    assign flush_pc = branch_target & ~XLEN'(3);

    // Next-state logic: flush outranks stall, hold and response except in boot.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_d      = hold_q;
        req_addr_d  = req_addr_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_din    = '{pc: pc_q, instr: imem_rdata, valid: 1'b1};

        // The address of an issued request is kept so DISCARD can keep
        // presenting it after pc has moved to the redirect target.
        if (state_q == S_FETCH) begin
            req_addr_d = pc_q;
        end

        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
                if (flush) begin
                    pc_d = flush_pc;
                end
            end
            S_FETCH: begin
                if (flush) begin
                    pc_d         = flush_pc;
                    ifid_bubble  = 1'b1;
                    hold_d.valid = 1'b0;
                    state_d      = imem_valid ? S_FETCH : S_DISCARD;
                end else if (imem_valid) begin
                    if (advance) begin
                        ifid_load = 1'b1;
                        pc_d      = pc_plus4;
                    end else begin
                        hold_d  = '{pc: pc_q, instr: imem_rdata, valid: 1'b1};
                        state_d = S_HOLD;
                    end
                end else if (advance) begin
                    ifid_bubble = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    pc_d         = flush_pc;
                    ifid_bubble  = 1'b1;
                    hold_d.valid = 1'b0;
                    state_d      = S_FETCH;
                end else if (advance) begin
                    ifid_load    = 1'b1;
                    ifid_din     = hold_q;
                    hold_d.valid = 1'b0;
                    pc_d         = pc_plus4;
                    state_d      = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (flush) begin
                    pc_d         = flush_pc;
                    ifid_bubble  = 1'b1;
                    hold_d.valid = 1'b0;
                end else begin
                    if (imem_valid) begin
                        state_d = S_FETCH;
                    end
                    if (advance) begin
                        ifid_bubble = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // State, PC, request address and hold buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            hold_q     <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            hold_q     <= hold_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (ifid_load),
        .bubble (ifid_bubble),
        .d      (ifid_din),
        .q      (ifid_q)
    );

    assign imem_req    = (state_q == S_FETCH) || (state_q == S_DISCARD);
    assign imem_addr   = (state_q == S_DISCARD) ? req_addr_q : pc_q;
    assign IF_ID_pc    = ifid_q.pc;
    assign IF_ID_instr = ifid_q.instr;
    assign IF_ID_valid = ifid_q.valid;

`ifdef IF_STALL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count stalled, non-flush cycles, sticking at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!advance && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles   = stall_cnt_q;
    assign stall_fsm_busy = (state_q == S_HOLD) || (state_q == S_DISCARD);
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the load-use hazard unit.
- Owns the PC register, the single-outstanding instruction-memory request handshake, a one-entry hold buffer and the IF/ID pipeline register.
- Consumes PCwrite/IF_IDwrite from hazard detection and the branch redirect from EX.
- Produces IF_ID_pc, IF_ID_instr and IF_ID_valid for decode, which feeds rs1/rs2 to hazard detection.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- PCwrite  in  1  hazard unit: 1 = PC may advance.
- IF_IDwrite  in  1  hazard unit: 1 = IF/ID may load.
- flush  in  1  EX branch/jump taken; redirect this cycle.
- branch_target  in  XLEN  redirect address, valid with flush.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address; stable while imem_req && !imem_valid.
- imem_rdata  in  32  instruction word, valid with imem_valid.
- imem_valid  in  1  response strobe; may assert in the same cycle as imem_req or any later cycle.
- IF_ID_pc  out  XLEN  PC of the instruction in IF/ID.
- IF_ID_instr  out  32  instruction in IF/ID.
- IF_ID_valid  out  1  0 = bubble.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, IF_ID_pc=0, IF_ID_instr=NOP_INSTR, IF_ID_valid=0, hold buffer empty, state=S_BOOT. Outputs take these values immediately on rst_n falling, mid-operation included; an in-flight response is lost and memory must tolerate that.
- advance = PCwrite & IF_IDwrite. A mismatched pair is treated as a stall; neither PC nor IF/ID changes.
- S_BOOT: one cycle with imem_req=0, then S_FETCH.
- S_FETCH: imem_req=1, imem_addr=pc.
  - imem_valid && advance: IF/ID <= {pc, imem_rdata, 1}; pc <= pc+4; stay in S_FETCH. This gives a throughput of 1 instr/cycle with zero-wait memory.
  - imem_valid && !advance: hold buffer <= {pc, imem_rdata}; go to S_HOLD. IF/ID keeps its value.
  - !imem_valid && advance: IF/ID <= bubble (NOP_INSTR, valid=0).
  - !imem_valid && !advance: IF/ID unchanged.
- S_HOLD: imem_req=0. When advance: IF/ID <= hold buffer with valid=1; pc <= pc+4; go to S_FETCH. Otherwise hold.
- S_DISCARD: imem_req=1, imem_addr is the old address (registered). On imem_valid, drop the data and go to S_FETCH at the redirected pc.
- flush has highest priority, over stall, hold and response, in every state except S_BOOT, where it is only latched into pc:
  - pc <= branch_target (bits [1:0] forced to 0).
  - IF/ID <= bubble, regardless of IF_IDwrite.
  - Hold buffer emptied.
  - In S_FETCH with !imem_valid: go to S_DISCARD. With imem_valid: data dropped; go to S_FETCH.
  - In S_DISCARD: stay in S_DISCARD, since the old response is still owed.
- pc arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0.
- Invariants: at most one outstanding request; imem_addr never changes while a request is outstanding.

Optional Feature:
- Macro IF_STALL_PERF_EN.
- Defined: adds output port stall_cycles (32 bits) and stall_fsm_busy (1 bit).
  - stall_cycles resets to 0 and increments every cycle with !advance && !flush.
  - It saturates at 32'hFFFF_FFFF and does not wrap.
  - stall_fsm_busy=1 in S_HOLD or S_DISCARD.
- Undefined: ports and counter absent; no other behavioural difference.

Decomposition:
- Shared package rv_pipe_pkg:
  - XLEN and NOP_INSTR constants.
  - fetch-state enum (S_BOOT, S_FETCH, S_HOLD, S_DISCARD).
  - if_id_t struct {pc, instr, valid}.
- One sub-module, if_id_reg: IF/ID register with load, bubble-insert and async active-low reset.
- FSM, PC and hold buffer stay in if_fetch_stage.

Test Plan:
- Reset/boot: release rst_n, zero-wait imem returning addr-tagged words. Expect no imem_req in the first cycle, then imem_addr 0,4,8,…. IF_ID_valid=1 from the 3rd cycle with IF_ID_pc=0, then 4, 8….
- Load-use stall: PCwrite=IF_IDwrite=0 for 1 cycle while imem_valid=1 at pc=0x10. Expect S_HOLD and IF/ID unchanged; on release IF_ID_pc=0x10 with the buffered word, next imem_addr=0x14, no instruction lost or duplicated.
- Slow memory: imem_valid 3 cycles after request. Expect imem_addr stable across all 3 cycles and IF_ID bubbles (instr=0x13, valid=0) while advancing.
- Flush during wait: request at 0x20 pending, flush with branch_target=0x100. Expect the 0x20 response discarded, next imem_addr=0x100, IF_ID_valid=0 for the flush cycle.
- Flush coincident with stall and hold: S_HOLD with PCwrite=0, flush=1, target=0x200. Expect hold buffer dropped, IF/ID bubble, fetch from 0x200.
- Reset mid-operation and wrap: assert rst_n=0 during S_DISCARD and expect immediate reset values. Separately, start at pc=0xFFFF_FFFC and expect the next imem_addr=0x0000_0000.
